voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphony controller for the synth voice bank: accepts note-on/note-off events over a valid/ready handshake and assigns each event to one of NUM_VOICES waveform-generator voices. It drives each voice's period, gate and phase-restart pulse, retriggers a voice already holding the same key, and steals the oldest voice when all are busy. It sits between the note/event decoder and the per-voice generators and mixer.

## Interface
- NUM_VOICES, 4: number of voices managed, 2..8.
- AGE_W, 8: width of per-voice saturating age counters.

- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- note_valid  in  1  event present.
- note_ready  out  1  allocator can accept an event; high exactly when FSM is IDLE.
- note_on  in  1  1 = note-on, 0 = note-off.
- note_key  in  7  key number identifying the note.
- note_period  in  32  generator period for note-on; ignored for note-off.
- voice_gate  out  NUM_VOICES  per-voice gate, 1 = sounding.
- voice_period  out  32*NUM_VOICES  per-voice period, voice v at bits [32v+31:32v].
- voice_key  out  7*NUM_VOICES  key held by each voice.
- voice_restart  out  NUM_VOICES  one-cycle pulse: restart the voice's generator phase.
- steal  out  1  one-cycle pulse when a note-on evicted a gated voice.

## Operation
- Event accepted on a clk edge where note_valid && note_ready; note_on/key/period captured into request registers.
- FSM: IDLE -> LOOKUP -> COMMIT -> IDLE, unconditional after acceptance. No other states.
- LOOKUP (register the decision):
  - match[v] = voice_gate[v] && voice_key[v] == req_key.
  - Note-on target, priority order: lowest-index match; else lowest-index voice with gate 0; else voice with largest age among gated voices, ties to lowest index (steal).
  - Note-off target: lowest-index match; none -> no action.
- COMMIT, note-on to voice t: voice_gate[t]=1, voice_key[t]=req_key, voice_period[t]=req_period, voice_restart[t] pulses, age[t]=0; every other gated voice has age += 1, saturating at 2^AGE_W-1; steal pulses only on the eviction path (not on retrigger).
- COMMIT, note-off to voice t: voice_gate[t]=0; key, period, age of t retained; no restart, no age change elsewhere.
- note_period = 0 is stored unmodified; no range checking.
- Ungated voices never age; their age is don't-care but must not affect selection.

## Timing
- Reset values: voice_gate 0, voice_period 0, voice_key 0, voice_restart 0, steal 0, all ages 0, FSM IDLE (note_ready reads 1, but no event is accepted while reset is high).
- Acceptance edge N; LOOKUP during cycle N+1; voice outputs and pulses update on edge N+2 and pulses fall on edge N+3.
- note_ready low for cycles N+1 and N+2, high again after edge N+2; maximum throughput one event per 3 cycles. Back-to-back events see the previous commit.
- Request fields only sampled at acceptance; changes while note_ready=0 are ignored.
- Reset asserted mid-operation: in-flight event dropped, no commit, all outputs to reset values immediately.
- All outputs registered; no combinational path from note_* inputs to any output except none (note_ready depends only on state).

## Test plan
- Reset then note-on key 60 period 1000 -> 2 edges after acceptance voice_gate=0001, voice_period[0]=1000, voice_key[0]=60, voice_restart=0001 for exactly one cycle, note_ready low 2 cycles.
- Note-on keys 60,62,64,65 then 67 (NUM_VOICES=4) -> voices 0..3 filled in order; key 67 steals voice 0 (oldest), steal=1 one cycle, voice_key[0]=67.
- Note-on key 62 while held in voice 1 with new period 500 -> voice 1 retriggered, period 500, restart pulse on voice 1, steal stays 0, no other voice changes.
- Note-off key 62 -> voice_gate[1]=0, period/key kept; note-off key 99 (absent) -> no output change, FSM returns to IDLE in 3 cycles.
- Hold note_valid high with 4 events queued -> accepted on every third edge, each committed in order; changing note_key while note_ready=0 has no effect.
- Assert reset in LOOKUP cycle of a note-on -> no gate set, all outputs 0, next event after reset accepted normally into voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphony controller: allocates note-on/note-off events to NUM_VOICES generator voices,
// with retrigger of a voice already holding the key and oldest-voice stealing when all are busy.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       note_valid,
    output logic                       note_ready,
    input  logic                       note_on,
    input  logic [6:0]                 note_key,
    input  logic [31:0]                note_period,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [32*NUM_VOICES-1:0]   voice_period,
    output logic [7*NUM_VOICES-1:0]    voice_key,
    output logic [NUM_VOICES-1:0]      voice_restart,
    output logic                       steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic             accept;

    logic             req_on;
    logic [6:0]       req_key;
    logic [31:0]      req_period;

    logic [31:0]      period_q [NUM_VOICES];
    logic [6:0]       key_q    [NUM_VOICES];
    logic [AGE_W-1:0] age_q    [NUM_VOICES];

    logic [IDX_W-1:0] tgt_q;
    logic             tgt_valid_q;
    logic             tgt_steal_q;

    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             old_found;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             sel_steal;

    assign note_ready = (state == IDLE);
    assign accept     = note_valid && note_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= LOOKUP;
                LOOKUP:  state <= COMMIT;
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are frozen at acceptance so input changes during LOOKUP/COMMIT are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_on     <= 1'b0;
            req_key    <= '0;
            req_period <= '0;
        end else if (accept) begin
            req_on     <= note_on;
            req_key    <= note_key;
            req_period <= note_period;
        end
    end

    // Lowest-index scans; strict '>' keeps the lowest index on age ties. Ungated voices are skipped.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_found   = 1'b0;
        old_idx     = '0;
        old_age     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!match_found && voice_gate[v] && key_q[v] == req_key) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(v);
            end
            if (!free_found && !voice_gate[v]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
            if (voice_gate[v] && (!old_found || age_q[v] > old_age)) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(v);
                old_age   = age_q[v];
            end
        end
    end

    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        sel_steal = 1'b0;
        if (req_on) begin
            sel_valid = 1'b1;
            if (match_found) begin
                sel_idx = match_idx;
            end else if (free_found) begin
                sel_idx = free_idx;
            end else begin
                sel_idx   = old_idx;
                sel_steal = old_found;
            end
        end else if (match_found) begin
            sel_valid = 1'b1;
            sel_idx   = match_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q       <= '0;
            tgt_valid_q <= 1'b0;
            tgt_steal_q <= 1'b0;
        end else if (state == LOOKUP) begin
            tgt_q       <= sel_idx;
            tgt_valid_q <= sel_valid;
            tgt_steal_q <= sel_steal;
        end
    end

    // Pulses default low every edge, so restart/steal last exactly one cycle after COMMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voice_gate    <= '0;
            voice_restart <= '0;
            steal         <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                period_q[v] <= '0;
                key_q[v]    <= '0;
                age_q[v]    <= '0;
            end
        end else begin
            voice_restart <= '0;
            steal         <= 1'b0;
            if (state == COMMIT && tgt_valid_q) begin
                if (req_on) begin
                    steal <= tgt_steal_q;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == tgt_q) begin
                            voice_gate[v]    <= 1'b1;
                            key_q[v]         <= req_key;
                            period_q[v]      <= req_period;
                            age_q[v]         <= '0;
                            voice_restart[v] <= 1'b1;
                        end else if (voice_gate[v] && age_q[v] != AGE_MAX) begin
                            age_q[v] <= age_q[v] + 1'b1;
                        end
                    end
                end else begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == tgt_q) begin
                            voice_gate[v] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_period[32*g +: 32] = period_q[g];
        assign voice_key[7*g +: 7]      = key_q[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events compared against
// a voice-table model that applies the allocation rules directly.
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int AGE_W   = 8;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic                clk;
    logic                reset;
    logic                note_valid;
    logic                note_ready;
    logic                note_on;
    logic [6:0]          note_key;
    logic [31:0]         note_period;
    logic [NV-1:0]       voice_gate;
    logic [32*NV-1:0]    voice_period;
    logic [7*NV-1:0]     voice_key;
    logic [NV-1:0]       voice_restart;
    logic                steal;

    int errors = 0;
    int checks = 0;

    bit          m_gate    [NV];
    int          m_key     [NV];
    int unsigned m_period  [NV];
    int          m_age     [NV];
    bit [NV-1:0] m_restart;
    bit          m_steal;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(AGE_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .note_on       (note_on),
        .note_key      (note_key),
        .note_period   (note_period),
        .voice_gate    (voice_gate),
        .voice_period  (voice_period),
        .voice_key     (voice_key),
        .voice_restart (voice_restart),
        .steal         (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s differs", tag);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_ready);
        logic [NV-1:0]    eg;
        logic [32*NV-1:0] ep;
        logic [7*NV-1:0]  ek;
        for (int v = 0; v < NV; v++) begin
            eg[v]         = m_gate[v];
            ep[32*v +: 32] = m_period[v];
            ek[7*v +: 7]   = 7'(m_key[v]);
        end
        checkValue({tag, ".gate"},    256'(voice_gate),    256'(eg));
        checkValue({tag, ".period"},  256'(voice_period),  256'(ep));
        checkValue({tag, ".key"},     256'(voice_key),     256'(ek));
        checkValue({tag, ".restart"}, 256'(voice_restart), 256'(m_restart));
        checkValue({tag, ".steal"},   256'(steal),         256'(m_steal));
        checkValue({tag, ".ready"},   256'(note_ready),    256'(exp_ready));
    endtask

    function automatic void modelReset();
        for (int v = 0; v < NV; v++) begin
            m_gate[v]   = 1'b0;
            m_key[v]    = 0;
            m_period[v] = 0;
            m_age[v]    = 0;
        end
        m_restart = '0;
        m_steal   = 1'b0;
    endfunction

    // Applies one event to the voice table using the allocation rules.
    function automatic void modelCommit(input bit on, input int key, input int unsigned period);
        int t;
        t = -1;
        m_restart = '0;
        m_steal   = 1'b0;
        for (int v = 0; v < NV; v++)
            if (t < 0 && m_gate[v] && m_key[v] == key) t = v;
        if (on) begin
            for (int v = 0; v < NV; v++)
                if (t < 0 && !m_gate[v]) t = v;
            if (t < 0) begin
                t = 0;
                for (int v = 1; v < NV; v++)
                    if (m_age[v] > m_age[t]) t = v;
                m_steal = 1'b1;
            end
            for (int v = 0; v < NV; v++)
                if (v != t && m_gate[v] && m_age[v] < AGE_MAX) m_age[v]++;
            m_gate[t]    = 1'b1;
            m_key[t]     = key;
            m_period[t]  = period;
            m_age[t]     = 0;
            m_restart[t] = 1'b1;
        end else if (t >= 0) begin
            m_gate[t] = 1'b0;
        end
    endfunction

    // Entered at a negedge with the allocator idle; leaves at the negedge after the commit edge.
    task automatic applyStimulus(input bit on, input int key, input int unsigned period, input bit keep_valid);
        checkValue("ready_on_entry", 256'(note_ready), 256'(1));
        for (int i = 0; i < 8 && note_ready !== 1'b1; i++) @(negedge clk);
        note_valid  = 1'b1;
        note_on     = on;
        note_key    = 7'(key);
        note_period = period;
        @(posedge clk);
        #1;
        note_valid  = keep_valid;
        note_key    = 7'($urandom);
        note_period = $urandom;
        note_on     = 1'($urandom);
        m_restart   = '0;
        m_steal     = 1'b0;
        @(negedge clk);
        checkOutput("lookup", 1'b0);
        note_key = 7'($urandom);
        @(negedge clk);
        checkValue("commit.ready", 256'(note_ready), 256'(0));
        modelCommit(on, key, period);
        @(negedge clk);
        checkOutput("done", 1'b1);
    endtask

    task automatic idleCheck(input string tag);
        @(negedge clk);
        m_restart = '0;
        m_steal   = 1'b0;
        checkOutput(tag, 1'b1);
    endtask

    initial begin
        int          s_key    [4];
        int unsigned s_period [4];
        bit          s_on     [4];

        reset       = 1'b1;
        note_valid  = 1'b0;
        note_on     = 1'b0;
        note_key    = '0;
        note_period = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] first note-on");
        applyStimulus(1'b1, 60, 1000, 1'b0);
        idleCheck("pulse_fall");

        $display("[TB] fill voices and steal");
        applyStimulus(1'b1, 62, 2000, 1'b0);
        applyStimulus(1'b1, 64, 3000, 1'b0);
        applyStimulus(1'b1, 65, 4000, 1'b0);
        applyStimulus(1'b1, 67, 5000, 1'b0);
        checkValue("steal_target_key", 256'(voice_key[6:0]), 256'(67));
        idleCheck("after_steal");

        $display("[TB] retrigger and note-off");
        applyStimulus(1'b1, 62, 500, 1'b0);
        applyStimulus(1'b0, 62, 0, 1'b0);
        applyStimulus(1'b0, 99, 0, 1'b0);
        idleCheck("after_off");

        $display("[TB] held valid stream");
        s_on = '{1'b1, 1'b1, 1'b0, 1'b1};
        s_key = '{10, 11, 65, 12};
        s_period = '{0, 321, 0, 9};
        for (int i = 0; i < 4; i++)
            applyStimulus(s_on[i], s_key[i], s_period[i], (i < 3));
        idleCheck("after_stream");

        $display("[TB] reset during lookup");
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_key    = 7'd70;
        note_period = 32'd1234;
        @(posedge clk);
        #1;
        note_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        modelReset();
        checkOutput("reset_mid", 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 72, 77, 1'b0);
        idleCheck("after_reset");

        $display("[TB] random events");
        for (int i = 0; i < 40; i++) begin
            bit          r_on;
            int          r_key;
            int unsigned r_period;
            r_on     = ($urandom_range(0, 9) < 7);
            r_key    = 60 + $urandom_range(0, 7);
            r_period = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
            applyStimulus(r_on, r_key, r_period, 1'b0);
        end
        idleCheck("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
